// File: rtl/issue_wf_arbiter.sv
// issue_wf_arbiter
// Picks one wavefront per cycle to offer to a functional unit. The offer is
// registered and held until the unit accepts it, a flush of that wavefront
// cancels it, or reset. Selection is round-robin from a pointer that moves to
// one past the last wavefront loaded.
//
// Ports
//   clk            : clock, all state updates on rising edge
//   rst            : synchronous active-high reset
//   ready_arry_gpr : per-WF operands ready (GPR dependency table)
//   valid_arry     : per-WF decoded instruction present in instruction buffer
//   flush_valid    : qualifies flush_wfid
//   flush_wfid     : wavefront being flushed; ids >= NUM_WF are ignored
//   fu_ready       : functional unit accepts the offered instruction
//   issue_valid    : registered, an instruction is offered
//   issue_wfid     : registered, wavefront of the offered instruction
//   issue_accept   : issue_valid & fu_ready, buffer retires the entry
module issue_wf_arbiter #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] ready_arry_gpr,
    input  logic [NUM_WF-1:0] valid_arry,
    input  logic              flush_valid,
    input  logic [WFID_W-1:0] flush_wfid,
    input  logic              fu_ready,
    output logic              issue_valid,
    output logic [WFID_W-1:0] issue_wfid,
    output logic              issue_accept
);

    localparam int                IDX_W    = WFID_W + 1;
    localparam logic [IDX_W-1:0]  NUM_WF_X = IDX_W'(NUM_WF);
    localparam logic [WFID_W-1:0] LAST_ID  = WFID_W'(NUM_WF - 1);

    logic              issue_valid_q, issue_valid_d;
    logic [WFID_W-1:0] issue_wfid_q,  issue_wfid_d;
    logic [WFID_W-1:0] ptr_q,         ptr_d;
    logic              last_vld_q,    last_vld_d;
    logic [WFID_W-1:0] last_wfid_q,   last_wfid_d;

    logic              handshake;
    logic              slot_free;
    logic              flush_hit;
    logic [NUM_WF-1:0] mask;
    logic [NUM_WF-1:0] eligible;
    logic              found;
    logic [WFID_W-1:0] pick;
    logic [IDX_W-1:0]  idx;

    assign handshake = issue_valid_q & fu_ready;
    assign slot_free = ~issue_valid_q | handshake;
    // A handshake wins over a same-cycle flush: the instruction already left.
    assign flush_hit = flush_valid & issue_valid_q & ~handshake &
                       (flush_wfid == issue_wfid_q);

    // The held offer and the just-accepted wfid are masked because the
    // instruction buffer only drops its valid bit one cycle after accept.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            if ((issue_valid_q && issue_wfid_q == WFID_W'(i)) ||
                (last_vld_q    && last_wfid_q  == WFID_W'(i)) ||
                (flush_valid   && flush_wfid   == WFID_W'(i))) begin
                mask[i] = 1'b1;
            end
        end
    end

    assign eligible = ready_arry_gpr & valid_arry & ~mask;

    // Round-robin scan upward from ptr; ptr is always < NUM_WF so a single
    // subtraction brings the sum back into range.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            idx = {1'b0, ptr_q} + IDX_W'(i);
            if (idx >= NUM_WF_X) begin
                idx = idx - NUM_WF_X;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx[WFID_W-1:0];
            end
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_wfid_d  = issue_wfid_q;
        ptr_d         = ptr_q;
        last_vld_d    = handshake;
        last_wfid_d   = handshake ? issue_wfid_q : last_wfid_q;

        if (flush_hit) begin
            // Refill waits one cycle so the flushed wfid cannot be reloaded.
            issue_valid_d = 1'b0;
        end else if (slot_free) begin
            if (found) begin
                issue_valid_d = 1'b1;
                issue_wfid_d  = pick;
                ptr_d         = (pick == LAST_ID) ? '0 : pick + 1'b1;
            end else begin
                issue_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_wfid_q  <= '0;
            ptr_q         <= '0;
            last_vld_q    <= 1'b0;
            last_wfid_q   <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_wfid_q  <= issue_wfid_d;
            ptr_q         <= ptr_d;
            last_vld_q    <= last_vld_d;
            last_wfid_q   <= last_wfid_d;
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_wfid   = issue_wfid_q;
    assign issue_accept = issue_valid_q & fu_ready;

endmodule

// File: tb/tb_issue_wf_arbiter.sv
// Bench for issue_wf_arbiter. Expected accepted wfids are queued as stimulus
// is applied; a negedge monitor pops and compares on every issue_accept.
module tb_issue_wf_arbiter;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_WF-1:0] ready_arry_gpr;
    logic [NUM_WF-1:0] valid_arry;
    logic              flush_valid;
    logic [WFID_W-1:0] flush_wfid;
    logic              fu_ready;
    logic              issue_valid;
    logic [WFID_W-1:0] issue_wfid;
    logic              issue_accept;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];

    issue_wf_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ready_arry_gpr (ready_arry_gpr),
        .valid_arry     (valid_arry),
        .flush_valid    (flush_valid),
        .flush_wfid     (flush_wfid),
        .fu_ready       (fu_ready),
        .issue_valid    (issue_valid),
        .issue_wfid     (issue_wfid),
        .issue_accept   (issue_accept)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [NUM_WF-1:0] bit_of(input int w);
        logic [NUM_WF-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        ready_arry_gpr = '0;
        valid_arry     = '0;
        fu_ready       = 1'b0;
        flush_valid    = 1'b0;
        flush_wfid     = '0;
        tick();
        tick();
        check_eq("rst_valid",  32'(issue_valid),  0);
        check_eq("rst_wfid",   32'(issue_wfid),   0);
        check_eq("rst_accept", 32'(issue_accept), 0);
        rst = 1'b0;
    endtask

    // Scoreboard: every accept must match the next queued wfid.
    always @(negedge clk) begin
        if (issue_accept === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("accept_unexpected", 32'(issue_wfid), 32'hFFFF);
            end else begin
                check_eq("accept_wfid", 32'(issue_wfid), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic              pend;
        logic [WFID_W-1:0] pw;
        int                acc_cnt;

        do_reset();

        // Full round robin with the buffer dropping valid one cycle after accept.
        ready_arry_gpr = '1;
        valid_arry     = '1;
        fu_ready       = 1'b1;
        for (int w = 0; w < NUM_WF; w++) exp_q.push_back(w);
        exp_q.push_back(0);
        pend    = 1'b0;
        pw      = '0;
        acc_cnt = 0;
        for (int i = 1; i <= 41; i++) begin
            tick();
            valid_arry = '1;
            if (pend) valid_arry[pw] = 1'b0;
            if (i == 41) ready_arry_gpr = '0;
            #1;
            pend = issue_accept;
            pw   = issue_wfid;
            if (issue_accept) acc_cnt++;
        end
        tick();
        check_eq("rr_accept_count", 32'(acc_cnt), 41);
        check_eq("rr_idle", 32'(issue_valid), 0);

        // Wrap: ptr moved to 6, then only 5 and 30 eligible.
        do_reset();
        ready_arry_gpr = bit_of(5);
        valid_arry     = bit_of(5);
        tick();
        check_eq("lat_valid", 32'(issue_valid), 1);
        check_eq("lat_wfid",  32'(issue_wfid),  5);
        exp_q.push_back(5);
        fu_ready       = 1'b1;
        ready_arry_gpr = '0;
        valid_arry     = '0;
        tick();
        check_eq("wrap_pre_idle", 32'(issue_valid), 0);
        ready_arry_gpr = bit_of(5) | bit_of(30);
        valid_arry     = bit_of(5) | bit_of(30);
        fu_ready       = 1'b0;
        exp_q.push_back(30);
        exp_q.push_back(5);
        tick();
        check_eq("wrap_first", 32'(issue_wfid), 30);
        fu_ready   = 1'b1;
        valid_arry = bit_of(5);
        tick();
        check_eq("wrap_second", 32'(issue_wfid), 5);
        ready_arry_gpr = '0;
        valid_arry     = '0;
        tick();
        check_eq("wrap_done", 32'(issue_valid), 0);
        fu_ready = 1'b0;
        tick();
        ready_arry_gpr = bit_of(5) | bit_of(7);
        valid_arry     = bit_of(5) | bit_of(7);
        tick();
        check_eq("ptr_after_wrap", 32'(issue_wfid), 7);

        // Stall hold while the GPR ready bit drops.
        do_reset();
        ready_arry_gpr = bit_of(12);
        valid_arry     = bit_of(12);
        tick();
        check_eq("stall_load", 32'(issue_wfid), 12);
        ready_arry_gpr = bit_of(3);
        valid_arry     = bit_of(3) | bit_of(12);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stall_valid", 32'(issue_valid), 1);
            check_eq("stall_wfid",  32'(issue_wfid),  12);
        end
        exp_q.push_back(12);
        fu_ready       = 1'b1;
        ready_arry_gpr = '0;
        valid_arry     = '0;
        tick();
        check_eq("stall_released", 32'(issue_valid), 0);

        // Flush of the held wfid, then flush racing a handshake.
        do_reset();
        ready_arry_gpr = bit_of(7);
        valid_arry     = bit_of(7);
        tick();
        check_eq("flush_load", 32'(issue_wfid), 7);
        flush_valid = 1'b1;
        flush_wfid  = 6'd7;
        tick();
        check_eq("flush_drop", 32'(issue_valid), 0);
        flush_valid = 1'b0;
        tick();
        check_eq("flush_refill_valid", 32'(issue_valid), 1);
        check_eq("flush_refill_wfid",  32'(issue_wfid),  7);
        exp_q.push_back(7);
        flush_valid    = 1'b1;
        fu_ready       = 1'b1;
        ready_arry_gpr = '0;
        valid_arry     = '0;
        #1;
        check_eq("flush_hs_accept", 32'(issue_accept), 1);
        tick();
        flush_valid = 1'b0;
        check_eq("flush_hs_idle", 32'(issue_valid), 0);
        ready_arry_gpr = bit_of(9) | bit_of(10);
        valid_arry     = bit_of(9) | bit_of(10);
        flush_valid    = 1'b1;
        flush_wfid     = 6'd9;
        fu_ready       = 1'b0;
        tick();
        check_eq("flush_excludes", 32'(issue_wfid), 10);
        flush_wfid = 6'd50;
        tick();
        flush_valid = 1'b0;
        check_eq("flush_oor_valid", 32'(issue_valid), 1);
        check_eq("flush_oor_wfid",  32'(issue_wfid),  10);

        // Valid bit lingers one cycle after accept: no re-offer.
        do_reset();
        ready_arry_gpr = bit_of(3);
        valid_arry     = bit_of(3);
        fu_ready       = 1'b1;
        exp_q.push_back(3);
        tick();
        check_eq("shadow_load", 32'(issue_wfid), 3);
        tick();
        check_eq("shadow_hs_cycle", 32'(issue_valid), 0);
        tick();
        check_eq("shadow_extra_cycle", 32'(issue_valid), 0);
        valid_arry = '0;
        tick();
        check_eq("shadow_cleared", 32'(issue_valid), 0);

        // Reset during a stall discards the offer and restarts from ptr 0.
        do_reset();
        ready_arry_gpr = bit_of(20);
        valid_arry     = bit_of(20);
        tick();
        check_eq("rst_stall_load", 32'(issue_wfid), 20);
        tick();
        check_eq("rst_stall_hold", 32'(issue_wfid), 20);
        rst = 1'b1;
        tick();
        check_eq("rst_mid_valid",  32'(issue_valid),  0);
        check_eq("rst_mid_wfid",   32'(issue_wfid),   0);
        check_eq("rst_mid_accept", 32'(issue_accept), 0);
        tick();
        ready_arry_gpr = bit_of(1) | bit_of(25);
        valid_arry     = bit_of(1) | bit_of(25);
        rst            = 1'b0;
        tick();
        check_eq("rst_restart_valid", 32'(issue_valid), 1);
        check_eq("rst_restart_wfid",  32'(issue_wfid),  1);

        tick();
        check_eq("sb_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/issue_wf_arbiter.md
ISSUE_WF_ARBITER -- requirements
Module: issue_wf_arbiter

Interface
REQ-001 SHALL have parameter NUM_WF, default 40, meaning number of wavefronts per CU (equal to `WF_PER_CU).
REQ-002 SHALL have parameter WFID_W, default 6, meaning wavefront-id width (equal to `WF_ID_LENGTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port ready_arry_gpr  input  NUM_WF  per-WF GPR operands ready, from the GPR dependency table.
REQ-006 SHALL have port valid_arry  input  NUM_WF  per-WF decoded instruction present in the instruction buffer.
REQ-007 SHALL have port flush_valid  input  1  qualifies flush_wfid.
REQ-008 SHALL have port flush_wfid  input  WFID_W  wavefront being flushed (branch/halt).
REQ-009 SHALL have port fu_ready  input  1  functional unit accepts the offered instruction this cycle.
REQ-010 SHALL have port issue_valid  output  1  an instruction is offered; registered.
REQ-011 SHALL have port issue_wfid  output  WFID_W  wavefront of the offered instruction; registered.
REQ-012 SHALL have port issue_accept  output  1  combinational issue_valid & fu_ready; tells the instruction buffer to retire the entry.

Function
REQ-013 SHALL define handshake as issue_valid & fu_ready in the same cycle.
REQ-014 SHALL compute eligible = ready_arry_gpr & valid_arry & ~mask, where mask contains bit issue_wfid when issue_valid=1, and bit last_wfid when last_vld=1.
REQ-015 SHALL register last_wfid <= issue_wfid and last_vld <= 1 on a handshake, and last_vld <= 0 in any cycle without a handshake (one-cycle shadow covering the buffer's valid-drop latency).
REQ-016 SHALL, when the offer slot is free (issue_valid=0, or handshake this cycle), load the first eligible wfid found scanning upward from ptr with wrap NUM_WF-1 -> 0, setting issue_valid=1; if none is eligible, set issue_valid=0.
REQ-017 SHALL, while issue_valid=1 and fu_ready=0, hold issue_valid and issue_wfid unchanged regardless of changes on ready_arry_gpr or valid_arry.
REQ-018 SHALL, on loading wfid w, set ptr <= w+1, wrapping to 0 when w=NUM_WF-1; ptr is unchanged when nothing is loaded.
REQ-019 SHALL give latency of exactly one cycle from an eligible bit rising (slot free) to issue_valid=1 for that wfid.
REQ-020 SHALL, on flush_valid=1 with flush_wfid equal to the held issue_wfid and no handshake in the same cycle, drop the offer (issue_valid <= 0 next cycle); the slot is then re-filled on the following cycle per REQ-016.
REQ-021 SHALL give a handshake priority over a simultaneous flush of the same wfid (instruction counts as issued).
REQ-022 SHALL exclude flush_wfid from eligible in the cycle flush_valid=1.
REQ-023 SHALL guarantee that no wfid is offered twice for a single instruction; a re-offer of the same wfid requires at least one cycle of last_vld covering it.
REQ-024 SHALL treat wfids >= NUM_WF on flush_wfid as no-ops.

Reset
REQ-025 SHALL, while rst=1, force issue_valid=0, issue_wfid=0, ptr=0, last_vld=0, last_wfid=0; issue_accept=0 follows from issue_valid=0.
REQ-026 SHALL, on rst asserted mid-stall (issue_valid=1, fu_ready=0), discard the offer; the first cycle after deassertion evaluates from ptr=0.

Verification
REQ-027 SHALL cover: after reset, ready=valid=all-ones, fu_ready=1 -> issue_wfid sequence 0,2,4... is NOT allowed; required 0,1,2,...,39,0 with the shadow of each wfid dropped by the buffer (valid bit cleared one cycle after accept).
REQ-028 SHALL cover: only wfid 5 and 30 eligible, ptr=6 -> issue_wfid=30 first, then 5 (wrap), ptr ends at 6.
REQ-029 SHALL cover: wfid 12 offered, fu_ready=0 for 4 cycles while ready_arry_gpr[12] drops -> issue_wfid holds 12, issue_valid stays 1, accepted on fu_ready=1.
REQ-030 SHALL cover: wfid 7 held, flush_valid=1, flush_wfid=7, fu_ready=0 -> issue_valid=0 next cycle; same stimulus with fu_ready=1 -> issue_accept=1, instruction counted issued.
REQ-031 SHALL cover: wfid 3 accepted, valid_arry[3] remains 1 for one extra cycle -> wfid 3 not re-offered in the cycle after accept.
REQ-032 SHALL cover: rst pulsed while wfid 20 held stalled -> issue_valid=0 during reset; next offer chosen from ptr=0.
